// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch unit for the multi-cycle core: owns the PC, reads each word over AR/R,
// hands it to decode with valid/ready, then waits for writeback to supply next_pc.
module ysyx_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] next_pc,
    input  logic        next_pc_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RESP,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fetch_err;
    logic [31:0] r_fetch_cnt;

    // NOTE: handshake outputs decode the state register alone, so the async reset
    // drops them immediately and no input reaches an output combinationally.
    assign arvalid    = (r_state == S_FETCH);
    assign rready     = (r_state == S_RESP);
    assign inst_valid = (r_state == S_ISSUE);
    assign araddr     = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign fetch_err  = r_fetch_err;
    assign fetch_cnt  = r_fetch_cnt;

    // NOTE: sequential state uses non-blocking assignments only; every register
    // holds its value by default, so no branch needs an explicit else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_inst      <= NOP;
            r_fetch_err <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (arready) r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rvalid) begin
                        r_inst <= rdata;
                        if (rresp != 2'b00) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_HALT;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A misaligned target is a fault; the PC keeps the faulting instruction's address.
                    if (next_pc_valid) begin
                        if (next_pc[1:0] != 2'b00) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_HALT;
                        end else begin
                            r_pc    <= next_pc;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Directed bench for ysyx_ifu_fetch: inputs change and outputs are sampled on the falling edge.
module tb_ysyx_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_ifu_fetch dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .next_pc(next_pc), .next_pc_valid(next_pc_valid),
        .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_hs(input string tag, input logic av, input logic rr, input logic iv);
        chk({tag, ".arvalid"}, {31'd0, arvalid}, {31'd0, av});
        chk({tag, ".rready"}, {31'd0, rready}, {31'd0, rr});
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, iv});
    endtask

    initial begin
        rst = 1'b1; arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rvalid = 1'b0;
        inst_ready = 1'b0; next_pc = 32'd0; next_pc_valid = 1'b0;
        tick();
        chk_hs("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.pc", pc, 32'h8000_0000);
        chk("rst.inst", inst, 32'h0000_0013);
        chk("rst.err", {31'd0, fetch_err}, 32'd0);
        chk("rst.cnt", fetch_cnt, 32'd0);

        // 1: minimum-latency fetch
        rst = 1'b0; arready = 1'b1;
        tick();
        chk_hs("t1.fetch", 1'b1, 1'b0, 1'b0);
        chk("t1.araddr", araddr, 32'h8000_0000);
        rvalid = 1'b1; rdata = 32'h0010_0093;
        tick();
        chk_hs("t1.resp", 1'b0, 1'b1, 1'b0);
        tick();
        rvalid = 1'b0; arready = 1'b0;
        chk_hs("t1.issue", 1'b0, 1'b0, 1'b1);
        chk("t1.inst", inst, 32'h0010_0093);
        chk("t1.pc", pc, 32'h8000_0000);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk_hs("t1.wait", 1'b0, 1'b0, 1'b0);
        chk("t1.cnt", fetch_cnt, 32'd1);
        next_pc = 32'h8000_0004; next_pc_valid = 1'b1;
        tick();
        next_pc_valid = 1'b0;
        chk_hs("t1.refetch", 1'b1, 1'b0, 1'b0);
        chk("t1.araddr2", araddr, 32'h8000_0004);

        // 2: address and data stalls; next_pc pulses outside WAIT must be ignored
        next_pc = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            next_pc_valid = (i == 1);
            tick();
            chk_hs("t2.arstall", 1'b1, 1'b0, 1'b0);
            chk("t2.araddr", araddr, 32'h8000_0004);
        end
        next_pc_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_pc_valid = (i == 2);
            chk_hs("t2.rstall", 1'b0, 1'b1, 1'b0);
            chk("t2.pc", pc, 32'h8000_0004);
            tick();
        end
        next_pc_valid = 1'b0;
        chk_hs("t2.rstall_end", 1'b0, 1'b1, 1'b0);
        rvalid = 1'b1; rdata = 32'h0020_8113;
        tick();
        rvalid = 1'b0;
        chk_hs("t2.issue", 1'b0, 1'b0, 1'b1);
        chk("t2.inst", inst, 32'h0020_8113);
        chk("t2.pc_issue", pc, 32'h8000_0004);

        // 3: decode back-pressure, next_pc on the handshake edge ignored, then self-loop
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_hs("t3.hold", 1'b0, 1'b0, 1'b1);
            chk("t3.inst", inst, 32'h0020_8113);
            chk("t3.cnt_hold", fetch_cnt, 32'd1);
        end
        inst_ready = 1'b1; next_pc = 32'h8000_0200; next_pc_valid = 1'b1;
        tick();
        inst_ready = 1'b0; next_pc_valid = 1'b0;
        chk("t3.cnt", fetch_cnt, 32'd2);
        tick();
        chk_hs("t3.wait", 1'b0, 1'b0, 1'b0);
        chk("t3.pc_kept", pc, 32'h8000_0004);
        next_pc = 32'h8000_0004; next_pc_valid = 1'b1;
        tick();
        next_pc_valid = 1'b0;
        chk_hs("t3.selfloop", 1'b1, 1'b0, 1'b0);
        chk("t3.araddr", araddr, 32'h8000_0004);

        // 5: misaligned next_pc halts with the old PC
        arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0073;
        tick();
        rvalid = 1'b0; inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t5.cnt", fetch_cnt, 32'd3);
        next_pc = 32'h8000_0006; next_pc_valid = 1'b1;
        tick();
        next_pc_valid = 1'b0;
        chk("t5.err", {31'd0, fetch_err}, 32'd1);
        chk("t5.pc", pc, 32'h8000_0004);
        chk_hs("t5.halt", 1'b0, 1'b0, 1'b0);
        arready = 1'b1; rvalid = 1'b1; inst_ready = 1'b1; next_pc = 32'h8000_0008; next_pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hs("t5.stay", 1'b0, 1'b0, 1'b0);
            chk("t5.pc_stay", pc, 32'h8000_0004);
        end
        chk("t5.cnt_stay", fetch_cnt, 32'd3);
        arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; next_pc_valid = 1'b0;

        // 4: error response on the first fetch
        rst = 1'b1;
        tick();
        chk("t4.err_clr0", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0; arready = 1'b1;
        tick();
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hdead_beef;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("t4.err", {31'd0, fetch_err}, 32'd1);
        chk_hs("t4.halt", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_hs("t4.stay", 1'b0, 1'b0, 1'b0);
        chk("t4.cnt", fetch_cnt, 32'd0);
        rst = 1'b1;
        tick();
        chk("t4.err_clr", {31'd0, fetch_err}, 32'd0);

        // 6: reset while in RESP drops handshakes asynchronously
        rst = 1'b0; arready = 1'b1;
        tick();
        tick();
        arready = 1'b0;
        chk_hs("t6.resp", 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_hs("t6.async", 1'b0, 1'b0, 1'b0);
        chk("t6.pc", pc, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0030_0193;
        tick();
        chk_hs("t6.fetch", 1'b1, 1'b0, 1'b0);
        chk("t6.araddr", araddr, 32'h8000_0000);
        tick();
        tick();
        arready = 1'b0; rvalid = 1'b0;
        chk_hs("t6.issue", 1'b0, 1'b0, 1'b1);
        chk("t6.inst", inst, 32'h0030_0193);
        chk("t6.cnt0", fetch_cnt, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6.cnt1", fetch_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
